motor_pwm: RTL and testbench
============================

MOTOR_PWM -- requirements
Module: motor_pwm

Interface
REQ-001 Parameter FRAME_CYCLES, default 2000000, frame period in clk cycles (20 ms at 100 MHz).
REQ-002 Parameter PW_FWD, default 200000, pulse width in cycles for direction=1 (2.0 ms).
REQ-003 Parameter PW_REV, default 100000, pulse width in cycles for direction=0 (1.0 ms).
REQ-004 Parameter PW_NEUTRAL, default 150000, stop-equivalent pulse width (1.5 ms).
REQ-005 Parameter RAMP_STEP, default 10000, maximum width change per frame when ramping.
REQ-006 clk  in  1  system clock, 100 MHz.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 motor_reset  in  1  stop request from the line-follower controller; 1 = motor off.
REQ-009 direction  in  1  rotation request from the line-follower controller; 1 = forward pulse, 0 = reverse pulse.
REQ-010 pwm  out  1  servo pulse to the motor.
REQ-011 frame_start  out  1  one-cycle strobe on the first cycle of each frame.
REQ-012 width_cur  out  18  pulse width applied in the current frame.

Function
REQ-013 The frame counter SHALL be 21 bits, count 0..FRAME_CYCLES-1, and wrap to 0.
REQ-014 FSM states SHALL be IDLE, PULSE_HIGH, PULSE_LOW.
REQ-015 In IDLE: pwm=0, counter=0, frame_start=0, width_cur=PW_NEUTRAL.
REQ-016 IDLE->PULSE_HIGH on the first clk edge where motor_reset=0; that cycle is counter=0 and frame_start=1.
REQ-017 At counter=0 the target width SHALL be latched: PW_FWD if direction=1, else PW_REV.
REQ-018 direction changes mid-frame SHALL NOT affect the current frame.
REQ-019 pwm SHALL be 1 exactly for counter values 0..width_cur-1 (width_cur high cycles per frame).
REQ-020 PULSE_HIGH->PULSE_LOW when counter=width_cur-1; PULSE_LOW->PULSE_HIGH on wrap (counter=FRAME_CYCLES-1).
REQ-021 Any state->IDLE on the clk edge where motor_reset=1; pwm drops the following cycle, even mid-pulse (truncation accepted).
REQ-022 If motor_reset toggles 1->0 within one frame, a fresh frame SHALL start at counter=0; no partial-frame resume.
REQ-023 frame_start SHALL pulse once per frame, including the first frame after leaving IDLE.
REQ-024 Width arithmetic SHALL be unsigned 18-bit; ramp results SHALL saturate at the target and never overshoot.

Reset
REQ-025 On reset=1 (asynchronous): state=IDLE, counter=0, pwm=0, frame_start=0, width_cur=PW_NEUTRAL.
REQ-026 Reset release SHALL NOT produce a pulse before a full IDLE->PULSE_HIGH transition per REQ-016.

Configuration
REQ-027 Macro MOTOR_PWM_RAMP_EN SHALL select ramping.
REQ-028 With MOTOR_PWM_RAMP_EN: at each counter=0, width_cur moves from its previous value toward the target by min(RAMP_STEP, |target-width_cur|); the first frame after IDLE starts from PW_NEUTRAL.
REQ-029 Without MOTOR_PWM_RAMP_EN: width_cur equals the latched target at every counter=0; RAMP_STEP is unused.

Structure
REQ-030 A shared package motor_pkg SHALL hold the state enum (motor_pwm_state_t) and the default timing constants (frame, forward, reverse, neutral, ramp step).
REQ-031 The frame counter SHALL be a sub-module pwm_frame_counter with synchronous clear, enable, and wrap output; the FSM and width logic stay in motor_pwm.
REQ-032 Two instances SHALL be used: one driven by motor_l_reset/motor_l_direction, one by motor_r_reset/motor_r_direction.

Verification
REQ-033 Reset, then motor_reset=0 and direction=1, ramp off -> first frame_start one cycle after release; pwm high 200000 cycles, low 1800000; period 2000000.
REQ-034 direction=0, ramp off -> pwm high 100000 cycles per frame; direction flipped to 1 at counter=50000 -> current frame stays 100000, next frame 200000.
REQ-035 motor_reset=1 at counter=120000 during a 200000 pulse -> pwm=0 from the next cycle; motor_reset=0 after 10 cycles -> new frame, frame_start=1, full 200000 pulse.
REQ-036 Ramp on, direction=1 from IDLE -> width_cur per frame: 160000, 170000, 180000, 190000, 200000, then constant.
REQ-037 Ramp on, steady 200000, direction set to 0 -> widths 190000 down to 100000 in 10 frames; no overshoot below 100000.
REQ-038 reset asserted mid-pulse, asynchronously to clk -> pwm=0 and width_cur=150000 without waiting for a clk edge.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and default timing for the servo-style motor PWM generator.
// Defaults assume a 100 MHz clk: 20 ms frame, 2.0/1.0/1.5 ms pulses.
package motor_pkg;

  localparam int unsigned CNT_W = 21;
  localparam int unsigned WID_W = 18;

  localparam int unsigned FRAME_CYCLES_DEF = 2000000;
  localparam int unsigned PW_FWD_DEF       = 200000;
  localparam int unsigned PW_REV_DEF       = 100000;
  localparam int unsigned PW_NEUTRAL_DEF   = 150000;
  localparam int unsigned RAMP_STEP_DEF    = 10000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PULSE_HIGH = 2'd1,
    PULSE_LOW  = 2'd2
  } motor_pwm_state_t;

  // Move cur toward tgt by at most step; lands exactly on tgt, never past it.
  function automatic logic [WID_W-1:0] ramp_toward(input logic [WID_W-1:0] cur,
                                                   input logic [WID_W-1:0] tgt,
                                                   input logic [WID_W-1:0] step);
    logic [WID_W-1:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff > step) ? (cur + step) : tgt;
    end else begin
      diff = cur - tgt;
      return (diff > step) ? (cur - step) : tgt;
    end
  endfunction

endpackage

// File: rtl/pwm_frame_counter.sv
// Free-running frame position counter, 0..FRAME_CYCLES-1 with wrap strobe.
// Synchronous clear has priority over enable.
module pwm_frame_counter
  import motor_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = (r_count == LP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : (r_count + CNT_W'(1));
    end
  end

endmodule

// File: rtl/motor_pwm.sv
// Servo pulse generator for one motor: one pulse per frame, width from direction.
// Define MOTOR_PWM_RAMP_EN to slew the width by RAMP_STEP per frame instead of jumping.
//
// state      | meaning
// IDLE       | motor off, counter held at 0, width parked at neutral
// PULSE_HIGH | pwm high, counter below width_cur
// PULSE_LOW  | pwm low for the remainder of the frame
module motor_pwm
  import motor_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned PW_FWD       = PW_FWD_DEF,
  parameter int unsigned PW_REV       = PW_REV_DEF,
  parameter int unsigned PW_NEUTRAL   = PW_NEUTRAL_DEF,
  parameter int unsigned RAMP_STEP    = RAMP_STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             motor_reset,
  input  logic             direction,
  output logic             pwm,
  output logic             frame_start,
  output logic [WID_W-1:0] width_cur
);

  localparam logic [WID_W-1:0] LP_FWD     = WID_W'(PW_FWD);
  localparam logic [WID_W-1:0] LP_REV     = WID_W'(PW_REV);
  localparam logic [WID_W-1:0] LP_NEUTRAL = WID_W'(PW_NEUTRAL);
  localparam logic [WID_W-1:0] LP_STEP    = WID_W'(RAMP_STEP);

  motor_pwm_state_t r_state;
  logic             r_pwm;
  logic             r_frame_start;
  logic [WID_W-1:0] r_width;

  logic [CNT_W-1:0] w_count;
  logic             w_wrap;
  logic             w_clr;
  logic             w_en;
  logic             w_pulse_end;
  logic [WID_W-1:0] w_target;
  logic [WID_W-1:0] w_next_width;

  // Counter sits at 0 through IDLE so the first active cycle is position 0.
  assign w_clr = motor_reset | (r_state == IDLE);
  assign w_en  = (r_state != IDLE);

  pwm_frame_counter #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_counter (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_count(w_count),
    .o_wrap (w_wrap)
  );

  assign w_target    = direction ? LP_FWD : LP_REV;
  assign w_pulse_end = (w_count == (CNT_W'(r_width) - CNT_W'(1)));

`ifdef MOTOR_PWM_RAMP_EN
  // r_width is parked at neutral in IDLE, so the first frame ramps from there.
  assign w_next_width = ramp_toward(r_width, w_target, LP_STEP);
`else
  logic w_unused_step;
  assign w_unused_step = ^LP_STEP;
  assign w_next_width  = w_target;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
      r_width       <= LP_NEUTRAL;
    end else if (motor_reset) begin
      r_state       <= IDLE;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
      r_width       <= LP_NEUTRAL;
    end else if ((r_state == IDLE) || w_wrap) begin
      r_state       <= (w_next_width != '0) ? PULSE_HIGH : PULSE_LOW;
      r_pwm         <= (w_next_width != '0);
      r_frame_start <= 1'b1;
      r_width       <= w_next_width;
    end else if ((r_state == PULSE_HIGH) && w_pulse_end) begin
      r_state       <= PULSE_LOW;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign pwm         = r_pwm;
  assign frame_start = r_frame_start;
  assign width_cur   = r_width;

endmodule

// File: tb/tb_motor_pwm.sv
// Bench for motor_pwm: left and right motor instances against a frame-level model,
// plus directed literal checks. Honours MOTOR_PWM_RAMP_EN like the design.
module tb_motor_pwm;

  localparam int FRAME = 200;
  localparam int FWD   = 20;
  localparam int REV   = 10;
  localparam int NEU   = 15;
  localparam int STEP  = 1;

`ifdef MOTOR_PWM_RAMP_EN
  localparam int EFF_STEP    = STEP;
  localparam int EXP_L1 [8]  = '{16, 17, 18, 19, 20, 20, 20, 20};
  localparam int EXP_R1 [8]  = '{14, 13, 12, 11, 10, 10, 10, 11};
  localparam int EXP_RESTART = 16;
  localparam int EXP_L2 [15] = '{17, 18, 19, 20, 19, 18, 17, 16, 15, 14, 13, 12, 11, 10, 10};
`else
  localparam int EFF_STEP    = 1 << 30;
  localparam int EXP_L1 [8]  = '{20, 20, 20, 20, 20, 20, 20, 20};
  localparam int EXP_R1 [8]  = '{10, 10, 10, 10, 10, 10, 10, 20};
  localparam int EXP_RESTART = 20;
  localparam int EXP_L2 [15] = '{20, 20, 20, 20, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        mr_l  = 1'b1;
  logic        dir_l = 1'b1;
  logic        mr_r  = 1'b1;
  logic        dir_r = 1'b0;
  logic        pwm_l, fs_l, pwm_r, fs_r;
  logic [17:0] wc_l, wc_r;

  int total = 0;
  int bad   = 0;

  motor_pwm #(
    .FRAME_CYCLES(FRAME), .PW_FWD(FWD), .PW_REV(REV), .PW_NEUTRAL(NEU), .RAMP_STEP(STEP)
  ) u_left (
    .clk(clk), .reset(reset), .motor_reset(mr_l), .direction(dir_l),
    .pwm(pwm_l), .frame_start(fs_l), .width_cur(wc_l)
  );

  motor_pwm #(
    .FRAME_CYCLES(FRAME), .PW_FWD(FWD), .PW_REV(REV), .PW_NEUTRAL(NEU), .RAMP_STEP(STEP)
  ) u_right (
    .clk(clk), .reset(reset), .motor_reset(mr_r), .direction(dir_r),
    .pwm(pwm_r), .frame_start(fs_r), .width_cur(wc_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: active flag, position within frame, width of the frame.
  bit m_act [2] = '{1'b0, 1'b0};
  int m_pos [2] = '{0, 0};
  int m_w   [2] = '{NEU, NEU};

  function automatic int new_width(input int w, input bit d);
    int tgt;
    tgt = d ? FWD : REV;
    if (tgt > w) return (tgt - w > EFF_STEP) ? w + EFF_STEP : tgt;
    return (w - tgt > EFF_STEP) ? w - EFF_STEP : tgt;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit mr, d;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 1'b0; m_pos[k] = 0; m_w[k] = NEU;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mr = (k == 0) ? mr_l : mr_r;
        d  = (k == 0) ? dir_l : dir_r;
        if (mr) begin
          m_act[k] = 1'b0; m_pos[k] = 0; m_w[k] = NEU;
        end else if (!m_act[k]) begin
          m_act[k] = 1'b1; m_pos[k] = 0; m_w[k] = new_width(NEU, d);
        end else begin
          m_pos[k] = m_pos[k] + 1;
          if (m_pos[k] == FRAME) begin
            m_pos[k] = 0;
            m_w[k]   = new_width(m_w[k], d);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_pwm_l", int'(pwm_l), int'(m_act[0] && (m_pos[0] < m_w[0])));
    chk("cmp_fs_l",  int'(fs_l),  int'(m_act[0] && (m_pos[0] == 0)));
    chk("cmp_wc_l",  int'(wc_l),  m_w[0]);
    chk("cmp_pwm_r", int'(pwm_r), int'(m_act[1] && (m_pos[1] < m_w[1])));
    chk("cmp_fs_r",  int'(fs_r),  int'(m_act[1] && (m_pos[1] == 0)));
    chk("cmp_wc_r",  int'(wc_r),  m_w[1]);
  end

  initial begin
    int hl, hr, nfs;

    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_l), 0);
    chk("rst_fs", int'(fs_l), 0);
    chk("rst_width", int'(wc_l), 15);

    reset = 1'b0; mr_l = 1'b0; mr_r = 1'b0;
    @(negedge clk);
    chk("first_fs", int'(fs_l), 1);
    chk("first_pwm", int'(pwm_l), 1);

    for (int f = 0; f < 8; f++) begin
      chk("frm_fs_l", int'(fs_l), 1);
      chk("frm_fs_r", int'(fs_r), 1);
      chk("frm_wc_l", int'(wc_l), EXP_L1[f]);
      chk("frm_wc_r", int'(wc_r), EXP_R1[f]);
      hl = 0; hr = 0; nfs = 0;
      for (int i = 0; i < FRAME; i++) begin
        hl  += int'(pwm_l);
        hr  += int'(pwm_r);
        nfs += int'(fs_l);
        if (f == 6 && i == 5) dir_r = 1'b1;
        @(negedge clk);
      end
      chk("frm_high_l", hl, EXP_L1[f]);
      chk("frm_low_l", FRAME - hl, FRAME - EXP_L1[f]);
      chk("frm_high_r", hr, EXP_R1[f]);
      chk("frm_fs_once", nfs, 1);
    end

    repeat (12) @(negedge clk);
    chk("pre_stop_pwm", int'(pwm_l), 1);
    mr_l = 1'b1;
    @(negedge clk);
    chk("stop_pwm", int'(pwm_l), 0);
    chk("stop_width", int'(wc_l), 15);
    repeat (9) @(negedge clk);
    mr_l = 1'b0;
    @(negedge clk);
    chk("restart_fs", int'(fs_l), 1);
    hl = 0;
    for (int i = 0; i < FRAME; i++) begin
      hl += int'(pwm_l);
      @(negedge clk);
    end
    chk("restart_high", hl, EXP_RESTART);

    for (int f = 0; f < 15; f++) begin
      chk("ramp_fs", int'(fs_l), 1);
      chk("ramp_wc", int'(wc_l), EXP_L2[f]);
      hl = 0;
      for (int i = 0; i < FRAME; i++) begin
        hl += int'(pwm_l);
        if (f == 3 && i == 50) dir_l = 1'b0;
        @(negedge clk);
      end
      chk("ramp_high", hl, EXP_L2[f]);
    end

    repeat (3) @(negedge clk);
    chk("pre_areset_pwm", int'(pwm_l), 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_pwm_l", int'(pwm_l), 0);
    chk("areset_wc_l", int'(wc_l), 15);
    chk("areset_wc_r", int'(wc_r), 15);
    chk("areset_fs_r", int'(fs_r), 0);
    @(negedge clk);
    mr_l = 1'b1; mr_r = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_pwm", int'(pwm_l), 0);
      chk("post_rst_fs", int'(fs_l), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
